seq_divider16: RTL
==================

# seq_divider16

Sequential 16-bit unsigned restoring divider: the inverse arithmetic unit to the shift-and-add multiplier, sharing its 16-bit operand and result widths. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the datapath and feeds the same RAM8/Reg16Bit storage.

## Interface
- WIDTH, 16, operand/result width; only 16 is verified.
- clk  input  1  rising-edge clock
- re  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high in RUN (and DONE)
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered result, held until next accepted start
- remainder  output  WIDTH  registered result, held until next accepted start
- div_by_zero  output  1  divisor was zero; held with results

## Operation
- States:
  - IDLE: wait for start.
  - RUN: 16 iterations.
  - DONE: done=1 for one cycle.
- IDLE, start=1 at an edge:
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and iteration counter (5 bits).
  - Go to RUN.
- RUN, per edge:
  - T = {R[WIDTH-1:0], Q[MSB]} − {0, D}.
  - If T is non-negative: R = T, shift 1 into Q LSB.
  - Otherwise: R = shifted value, shift 0 into Q LSB.
  - Increment counter.
- Count 16 reached: load quotient=Q and remainder=R[WIDTH-1:0], go to DONE.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; there is no queueing.
- Arithmetic is unsigned. Remainder is always < divisor when divisor ≠ 0.
- Divisor 0 (natural restoring result): quotient=16'hFFFF, remainder=dividend.
- Reset: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. Reset asserted mid-RUN aborts the operation with no done pulse.

## Timing
- Start accepted at edge E0.
- RUN iterations occur at E1..E16.
- done=1, busy=1 and results valid in the cycle following E16: start-to-done latency is 16 cycles.
- E17: busy=0, done=0, back in IDLE.
- Minimum spacing of accepted starts is 18 edges: the next start can be accepted at E18.
- Outputs change only on clk edges, except asynchronous clearing on re.

## Configuration
- DIVIDER_ZERO_SHORTCUT_EN defined:
  - In IDLE, an accepted start with divisor==0 goes directly to DONE at E0.
  - Results: quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
  - done is high in the cycle after E0 (latency 1).
- Undefined:
  - Divisor 0 runs the full 16 iterations and yields the same quotient/remainder at latency 16.
  - div_by_zero is tied to 0.

## Structure
- Package div_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - DIV_WIDTH = 16
  - DIV_CNT_W = 5
  - DIV_ITER = 16
- Sub-module div_step: combinational single iteration.
  - Inputs: R, Q MSB, D.
  - Outputs: next R and quotient bit.
- Top level holds the FSM, counter and output registers.

## Test plan
- 100/7: start at E0 → done in the cycle after E16; quotient=14, remainder=2, busy high E0..E17.
- 65535/1 → quotient=65535, remainder=0; 5/10 → quotient=0, remainder=5.
- Divisor 0, dividend 1234, both configurations:
  - Macro defined: done after 1 cycle, div_by_zero=1, quotient=FFFF, remainder=1234.
  - Macro undefined: done after 16 cycles, div_by_zero=0, same quotient and remainder.
- start re-pulsed with new operands at E5 during RUN → ignored; the original result is delivered; a start at E18 is accepted.
- re asserted at E8 mid-RUN → all outputs 0 immediately, no done pulse; a new 50/3 run after release gives quotient=16, remainder=2.
- Random unsigned pairs with divisor ≠ 0 (≥1000) → quotient*divisor+remainder==dividend and remainder<divisor.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;
    localparam int DIV_ITER  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of D from the shifted remainder.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    assign w_shift = {i_r[WIDTH-1:0], i_q_msb};
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_d};
    // A set top bit of R means the true shifted value already exceeds any D
    assign w_ge    = ~w_diff[WIDTH+1] | i_r[WIDTH];

    always_comb begin
        o_q_bit = w_ge;
        o_r     = w_shift;
        if (w_ge) begin
            o_r = w_diff[WIDTH:0];
        end
    end

endmodule

// File: rtl/seq_divider16.sv
// 16-bit unsigned sequential restoring divider, one quotient bit per clock.
// Optional DIVIDER_ZERO_SHORTCUT_EN: divisor 0 finishes immediately and flags div_by_zero.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             re,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_d;
    logic [WIDTH:0]         r_r;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_quot;
    logic [WIDTH-1:0]       r_rem;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
    logic                   r_dbz;
`endif

    logic [WIDTH:0]         w_r_next;
    logic                   w_q_bit;
    logic [WIDTH-1:0]       w_q_next;
    logic                   w_last;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_r     (r_r),
        .i_q_msb (r_q[WIDTH-1]),
        .i_d     (r_d),
        .o_r     (w_r_next),
        .o_q_bit (w_q_bit)
    );

    assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};
    assign w_last   = (r_cnt == DIV_CNT_W'(DIV_ITER - 1));

    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_q    <= dividend;
                        r_d    <= divisor;
                        r_r    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        r_state <= RUN;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
                        if (divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Final iteration: publish results on the same edge
                    if (w_last) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
                        r_dbz   <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
